// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between a requester
// and a one-cycle-latency big-endian memory stage. Byte stores are done as
// read-modify-write of the 16-bit word at the byte address.
module lsu_ctrl #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_sext,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        RMW_RD,
        RMW_WAIT,
        RMW_WR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        acc_err;
    logic        byte_r;
    logic        sext_r;
    logic [7:0]  wbyte_r;

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // Word accesses at 8'hFF would spill past the address space; odd word
    // addresses are rejected only when alignment checking is enabled.
    assign acc_err = !req_byte &&
                     ((req_addr == 8'hFF) || (ALIGN_CHECK && req_addr[0]));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and memory strobes, both decoded from the state.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !acc_err) begin
                    if (!req_we) begin
                        next_state = RD;
                    end else if (req_byte) begin
                        next_state = RMW_RD;
                    end else begin
                        next_state = WR;
                    end
                end
            end
            RD: begin
                mem_read   = 1'b1;
                next_state = RWAIT;
            end
            RWAIT: begin
                next_state = IDLE;
            end
            WR: begin
                mem_write  = 1'b1;
                next_state = IDLE;
            end
            RMW_RD: begin
                mem_read   = 1'b1;
                next_state = RMW_WAIT;
            end
            RMW_WAIT: begin
                next_state = RMW_WR;
            end
            RMW_WR: begin
                mem_write  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, memory address/data registers and the response pulse.
    // NOTE: the datapath registers are reset too, because the outputs they
    // drive must read as zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_r    <= 1'b0;
            sext_r    <= 1'b0;
            wbyte_r   <= 8'h00;
            mem_addr  <= 8'h00;
            mem_wdata <= 16'h0000;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 16'h0000;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            if (accept) begin
                byte_r  <= req_byte;
                sext_r  <= req_sext;
                wbyte_r <= req_wdata[7:0];
                if (acc_err) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 16'h0000;
                end else begin
                    mem_addr <= req_addr;
                    if (req_we && !req_byte) begin
                        mem_wdata <= req_wdata;
                    end
                end
            end

            case (state)
                RWAIT: begin
                    rsp_valid <= 1'b1;
                    if (byte_r) begin
                        rsp_rdata <= {{8{sext_r & mem_rdata[15]}}, mem_rdata[15:8]};
                    end else begin
                        rsp_rdata <= mem_rdata;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 16'h0000;
                end
                RMW_WAIT: begin
                    // New byte goes to addr, old byte at addr+1 is written back unchanged.
                    mem_wdata <= {wbyte_r, mem_rdata[7:0]};
                end
                RMW_WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 16'h0000;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ALIGN_CHECK, default 1: when 1, a word access at an odd address SHALL be rejected with an error.
REQ-002 clk  in  1  clock; all state SHALL be updated on the rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_byte  in  1  1 = byte access, 0 = 16-bit word access.
REQ-008 req_sext  in  1  byte load: 1 = sign-extend, 0 = zero-extend; ignored otherwise.
REQ-009 req_addr  in  8  byte address.
REQ-010 req_wdata  in  16  store data; a byte store uses [7:0].
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_rdata  out  16  load result; 16'h0000 on stores and errors.
REQ-013 rsp_err  out  1  access rejected; qualified by rsp_valid.
REQ-014 mem_read  out  1  read strobe to the memory stage.
REQ-015 mem_write  out  1  write strobe to the memory stage.
REQ-016 mem_addr  out  8  memory byte address.
REQ-017 mem_wdata  out  16  memory write word, big-endian: [15:8] goes to addr and [7:0] to addr+1.
REQ-018 mem_rdata  in  16  memory read word, valid in the cycle after the edge that samples mem_read.

Function
REQ-019 States SHALL be IDLE, RD, RWAIT, WR, RMW_RD, RMW_WAIT and RMW_WR; req_ready SHALL equal (state==IDLE).
REQ-020 A request SHALL be accepted at the edge where req_valid and req_ready are both 1; the address, data and control fields SHALL be registered at that edge and held until the response.
REQ-021 Error check at acceptance: a word access with req_addr==8'hFF SHALL always be an error, and a word access with req_addr[0]==1 SHALL be an error when ALIGN_CHECK=1.
REQ-022 On an error the block SHALL stay in IDLE, and in the next cycle assert rsp_valid=1 and rsp_err=1 with no mem_read or mem_write asserted.
REQ-023 Load: IDLE->RD (mem_read=1)->RWAIT; at the end of RWAIT, mem_rdata SHALL be captured, rsp_valid SHALL be asserted in the next cycle and the state SHALL return to IDLE.
REQ-023a Load latency SHALL be rsp_valid 3 cycles after the accept edge.
REQ-024 Word load: rsp_rdata = mem_rdata.
REQ-024a Byte load: rsp_rdata = {8{sext & mem_rdata[15]}, mem_rdata[15:8]}, where mem_rdata[15:8] is the byte at req_addr.
REQ-025 Word store: IDLE->WR with mem_write=1 and mem_wdata=req_wdata for exactly one cycle, then IDLE; rsp_valid SHALL follow 2 cycles after the accept edge.
REQ-026 Byte store (read-modify-write): RMW_RD (mem_read=1) -> RMW_WAIT (capture mem_rdata) -> RMW_WR (mem_write=1, mem_wdata={req_wdata[7:0], captured[7:0]}) -> IDLE.
REQ-026a Byte store: rsp_valid SHALL follow 4 cycles after the accept edge, so that byte addr+1 is rewritten with its own old value.
REQ-027 mem_read and mem_write SHALL never be asserted in the same cycle, and each SHALL be asserted for exactly one cycle per access.
REQ-028 mem_addr SHALL equal the registered address whenever a strobe is high; outside strobes mem_addr and mem_wdata SHALL hold their last value.
REQ-029 rsp_valid SHALL be a single-cycle pulse, with no backpressure.
REQ-029a A new request MAY be accepted in the same cycle as rsp_valid, because the state is already IDLE.
REQ-030 A request presented while req_ready=0 SHALL be ignored and not queued; the requester holds it.
REQ-031 Byte accesses at 8'hFF SHALL be legal; the read-modify-write SHALL touch only the word at 8'hFF, and no address arithmetic SHALL be performed in this block.

Reset
REQ-032 While reset=0 the block SHALL hold: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=16'h0000, mem_read=0, mem_write=0, mem_addr=8'h00, mem_wdata=16'h0000.
REQ-033 Reset asserted mid-operation SHALL abort the access at once with no response; a read-modify-write cut before RMW_WR SHALL leave memory unmodified.
REQ-034 req_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-035 Word load at 8'h04 with memory 0x1234 -> mem_read pulse at addr 04; rsp_valid at accept+3 with rsp_rdata=16'h1234 and rsp_err=0.
REQ-036 Byte load at 8'h06 with memory 0xDEAD -> sext=1 gives 16'hFFDE; sext=0 gives 16'h00DE.
REQ-037 Byte store 8'h5A at 8'h04 over 0x1234 -> mem_read, then mem_write with mem_wdata=16'h5A34; a following word load at 04 returns 16'h5A34.
REQ-038 Word load at 8'h05 (ALIGN_CHECK=1), and a word store at 8'hFF (either setting) -> rsp_valid with rsp_err=1 one cycle after accept; no memory strobe.
REQ-039 Back-to-back: a word store 16'hBEEF at 8'h08 with a load held pending -> the load is accepted in the rsp_valid cycle of the store and returns 16'hBEEF.
REQ-040 reset pulled low in RMW_WAIT -> no mem_write, no rsp_valid; a later load shows the original memory word.
